popcount_sched: RTL and testbench

- Round-robin scheduler that shares one 36-bit bitcount datapath between two requesters.
- Each requester streams a job: one or more 36-bit beats, the final beat flagged last. The block counts set bits per beat through a registered pipeline stage and accumulates them. It returns one result per job, tagged with the requester id.
- Sits beside the pipeline as a multi-cycle functional unit; typical requesters are the execute stage and a debug/DMA port.

---
 rtl/popcount_sched_pkg.sv | 15 +
 rtl/popcount_sched_if.sv | 29 ++
 rtl/popcount_sched_counter.sv | 15 +
 rtl/popcount_sched.sv | 93 +++++++++
 tb/tb_popcount_sched.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/popcount_sched_pkg.sv
// popcount_sched_pkg: shared widths and FSM encoding for the shared bitcount scheduler.
package popcount_sched_pkg;

    localparam int DATA_W = 36;
    localparam int CNT_W  = 6;
    localparam int NREQ   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/popcount_sched_if.sv
// popcount_sched_if: requester beat streams and result channel of the shared bitcount unit.
interface popcount_sched_if
    import popcount_sched_pkg::*;
#(
    parameter int ACC_W = 12
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        req_ready;
    logic                   res_valid;
    logic                   res_ready;
    logic [ACC_W-1:0]       res_count;
    logic                   res_id;
    logic                   res_sat;
    logic                   busy;

    modport master (
        output req_valid, req_data, req_last, res_ready,
        input  req_ready, res_valid, res_count, res_id, res_sat, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, res_ready,
        output req_ready, res_valid, res_count, res_id, res_sat, busy
    );

endinterface

// File: rtl/popcount_sched_counter.sv
// popcount_sched_counter: combinational set-bit count of one 36-bit beat.
module popcount_sched_counter
    import popcount_sched_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < DATA_W; i++)
            count = count + CNT_W'(data[i]);
    end

endmodule

// File: rtl/popcount_sched.sv
// popcount_sched: round-robin share of one bitcount datapath between two beat streams,
// accumulating a saturating per-job total returned with the owning requester id.
module popcount_sched
    import popcount_sched_pkg::*;
#(
    parameter int ACC_W = 12,
    parameter int CNT_W = popcount_sched_pkg::CNT_W
) (
    input logic             clock,
    input logic             resetn,
    popcount_sched_if.slave bus
);

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic             owner_q, owner_d;
    logic             cnt_v_q, cnt_v_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;

    logic [DATA_W-1:0] beat;
    logic [CNT_W-1:0]  beat_cnt;
    logic [ACC_W:0]    sum;
    logic              accept;

    assign beat   = owner_q ? bus.req_data[2*DATA_W-1:DATA_W] : bus.req_data[DATA_W-1:0];
    assign accept = (state_q == RUN) && bus.req_valid[owner_q];
    // One extra bit so the carry out of the add flags saturation.
    assign sum    = {1'b0, acc_q} + (ACC_W+1)'(cnt_q);

    popcount_sched_counter u_counter (
        .data  (beat),
        .count (beat_cnt)
    );

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        cnt_d   = accept ? beat_cnt : cnt_q;
        cnt_v_d = accept;
        acc_d   = cnt_v_q ? (sum[ACC_W] ? '1 : sum[ACC_W-1:0]) : acc_q;
        sat_d   = sat_q | (cnt_v_q & sum[ACC_W]);
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    owner_d = (&bus.req_valid) ? rr_q : bus.req_valid[1];
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN:     state_d = (accept && bus.req_last[owner_q]) ? DRAIN : RUN;
            DRAIN:   state_d = DONE;
            DONE: begin
                if (bus.res_ready) begin
                    rr_d    = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            cnt_v_q <= 1'b0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            cnt_v_q <= cnt_v_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    assign bus.req_ready = (state_q == RUN) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_count = acc_q;
    assign bus.res_id    = owner_q;
    assign bus.res_sat   = sat_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_popcount_sched.sv
// tb_popcount_sched: scoreboard bench for popcount_sched; per-requester beat queues feed the
// DUT and a model-built result queue is compared against every result the DUT presents.
module tb_popcount_sched;
    import popcount_sched_pkg::*;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              last;
        int                gap;
    } beat_t;

    typedef struct {
        logic        id;
        logic [11:0] cnt;
        logic        sat;
    } res_t;

    logic clock  = 1'b0;
    logic resetn = 1'b1;

    popcount_sched_if #(.ACC_W(12)) bus ();

    popcount_sched #(.ACC_W(12)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    beat_t bq[2][$];
    res_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    age    = -1;
    int    stall  = 0;
    int    nacc[2];
    int    msum[2];
    logic  msat[2];
    logic  rr_m       = 1'b0;
    logic  grant_pend = 1'b0;
    logic  g_exp      = 1'b0;
    logic [1:0] fired = 2'b00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Queues one beat and advances the reference saturating sum; the last beat emits a result.
    task automatic add_beat(input int k, input logic [DATA_W-1:0] d, input logic last,
                            input int gap, input logic keep);
        beat_t b;
        res_t  r;
        b.d = d;
        b.last = last;
        b.gap = gap;
        bq[k].push_back(b);
        msum[k] += $countones(d);
        if (msum[k] > 4095) begin
            msum[k] = 4095;
            msat[k] = 1'b1;
        end
        if (last) begin
            r.id  = k[0];
            r.cnt = msum[k][11:0];
            r.sat = msat[k];
            if (keep) exp_q.push_back(r);
            msum[k] = 0;
            msat[k] = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bq[0].size() != 0 || bq[1].size() != 0 || exp_q.size() != 0) && n < 5000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 5000) chk("timeout_idle", 1, 0);
        repeat (2) @(negedge clock);
    endtask

    // Driver and monitor share one negedge loop so handshakes are seen in a fixed order.
    initial begin
        beat_t h;
        res_t  e;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.res_ready = 1'b0;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                bus.req_valid = '0;
                bus.res_ready = 1'b0;
                fired = 2'b00;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (fired[k] && bq[k].size() > 0) begin
                        h = bq[k].pop_front();
                        nacc[k]++;
                    end
                end
                if (age >= 0) begin
                    age++;
                    if (age == 1) chk("lat_drain", bus.res_valid, 0);
                    else if (age == 2) begin
                        chk("lat_done", bus.res_valid, 1);
                        age = -1;
                    end
                end
                if (grant_pend) begin
                    chk("grant", bus.req_ready, g_exp ? 2'b10 : 2'b01);
                    grant_pend = 1'b0;
                end
                for (int k = 0; k < 2; k++) begin
                    bus.req_valid[k] = 1'b0;
                    if (bq[k].size() > 0) begin
                        h = bq[k][0];
                        if (h.gap > 0) begin
                            h.gap--;
                            bq[k][0] = h;
                        end else begin
                            bus.req_valid[k] = 1'b1;
                            bus.req_data[k*DATA_W +: DATA_W] = h.d;
                            bus.req_last[k] = h.last;
                        end
                    end
                end
                if (!bus.busy || bus.res_valid) chk("rdy_off", bus.req_ready, 0);
                if (!bus.busy && |bus.req_valid) begin
                    grant_pend = 1'b1;
                    g_exp = (&bus.req_valid) ? rr_m : bus.req_valid[1];
                end
                fired = bus.req_valid & bus.req_ready;
                for (int k = 0; k < 2; k++)
                    if (fired[k] && bus.req_last[k]) age = 0;
                bus.res_ready = !(bus.res_valid && stall > 0);
                if (bus.res_valid && stall > 0) stall--;
                if (bus.res_valid) begin
                    if (exp_q.size() == 0) chk("res_unexpected", 1, 0);
                    else begin
                        e = exp_q[0];
                        chk("res_id", bus.res_id, e.id);
                        chk("res_count", bus.res_count, e.cnt);
                        chk("res_sat", bus.res_sat, e.sat);
                        if (bus.res_ready) begin
                            rr_m = ~e.id;
                            e = exp_q.pop_front();
                        end
                    end
                end
            end
        end
    end

    initial begin
        int   n;
        int   base;
        logic first;
        nacc[0] = 0; nacc[1] = 0;
        msum[0] = 0; msum[1] = 0;
        msat[0] = 1'b0; msat[1] = 1'b0;
        #1 resetn = 1'b0;
        repeat (2) @(negedge clock);
        #1 chk("reset_outputs", {bus.req_ready, bus.res_valid, bus.res_count, bus.res_id,
                                 bus.res_sat, bus.busy}, 0);
        resetn = 1'b1;

        add_beat(0, 36'hF_FFFF_FFFF, 1'b1, 0, 1'b1);
        wait_idle();

        add_beat(1, 36'h1, 1'b0, 0, 1'b1);
        add_beat(1, 36'h3, 1'b0, 1, 1'b1);
        add_beat(1, 36'h0, 1'b1, 0, 1'b1);
        wait_idle();

        first = rr_m;
        for (int j = 0; j < 4; j++) begin
            add_beat(int'(first), 36'h7, 1'b1, 0, 1'b1);
            add_beat(int'(~first), 36'h7, 1'b1, 0, 1'b1);
        end
        wait_idle();

        for (int j = 0; j < 120; j++) add_beat(0, 36'hF_FFFF_FFFF, j == 119, 0, 1'b1);
        add_beat(0, 36'h1, 1'b1, 0, 1'b1);
        wait_idle();

        stall = 10;
        add_beat(0, 36'hFF, 1'b1, 0, 1'b1);
        repeat (2) @(negedge clock);
        add_beat(1, 36'h3, 1'b1, 0, 1'b1);
        wait_idle();
        chk("stall_used", stall, 0);

        base = nacc[0];
        for (int j = 0; j < 5; j++) add_beat(0, 36'hF_FFFF_FFFF, j == 4, 0, 1'b0);
        n = 0;
        while (nacc[0] < base + 2 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) chk("timeout_midjob", 1, 0);
        #1 resetn = 1'b0;
        #1 chk("reset_midjob", {bus.req_ready, bus.res_valid, bus.res_count, bus.res_id,
                                bus.res_sat, bus.busy}, 0);
        bq[0].delete();
        bq[1].delete();
        exp_q.delete();
        age = -1;
        grant_pend = 1'b0;
        rr_m = 1'b0;
        stall = 0;
        msum[0] = 0; msum[1] = 0;
        msat[0] = 1'b0; msat[1] = 1'b0;
        repeat (2) @(negedge clock);
        #1 resetn = 1'b1;
        add_beat(0, 36'hF, 1'b1, 0, 1'b1);
        wait_idle();

        chk("exp_left", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
